fft_io_sequencer: RTL
=====================

Name: fft_io_sequencer

Overview:
- Top-level phase sequencer for the in-place radix-2 FFT core.
- Accepts a stream of N complex samples over valid/ready and writes them into the ping-pong RAM bank 0 (optionally in bit-reversed order).
- Then pulses the transform controller's start, waits for its done, and streams the N results out of the final bank over valid/ready at full throughput.
- Sits between the external sample interface and the RAM1/RAM2 banks plus the stage/pair transform controller.

Parameters:
- N, 16, FFT length; power of two, 4..1024.
- I, 8, integer bits of each fixed-point component.
- F, 8, fraction bits of each fixed-point component; component width W = I+F.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- i_in_valid  in  1  input sample valid
- o_in_ready  out  1  sequencer accepts an input sample
- i_in_re  in  W  input real part
- i_in_im  in  W  input imaginary part
- o_out_valid  out  1  output sample valid
- i_out_ready  in  1  downstream accepts an output sample
- o_out_re  out  W  output real part
- o_out_im  out  W  output imaginary part
- o_out_last  out  1  marks output sample index N-1
- o_ld_wr_en  out  1  write strobe to bank 0 (re and im)
- o_ld_wr_addr  out  clog2(N)  load write address
- o_ld_wr_re  out  W  load write data, real part
- o_ld_wr_im  out  W  load write data, imaginary part
- o_ul_rd_en  out  1  read strobe to the result bank
- o_ul_rd_addr  out  clog2(N)  unload read address
- o_ul_bank  out  1  result bank select; constant clog2(N)%2, where 0 = RAM1 and 1 = RAM2
- i_ul_rd_re  in  W  result-bank read data, real part; valid 1 cycle after o_ul_rd_en
- i_ul_rd_im  in  W  result-bank read data, imaginary part
- o_xform_start  out  1  one-cycle start pulse to the transform controller
- i_xform_done  in  1  transform controller finished (pulse or level)
- o_busy  out  1  high in any state other than IDLE
- o_phase  out  2  current state encoding

Behaviour:
- Reset: every output register is 0; state is IDLE; counters and FIFO are cleared. Reset asserted mid-operation aborts immediately, and any in-flight read data is discarded.
- State encoding: IDLE=0, LOAD=1, XFORM=2, UNLOAD=3.
- IDLE: o_in_ready=1. The first accepted input (i_in_valid & o_in_ready) is written at the index-0 address and the state moves to LOAD. The load counter (clog2(N)+1 bits) becomes 1.
- LOAD: o_in_ready=1.
  - Each accepted sample drives o_ld_wr_en=1 in the same cycle, with write data equal to the input and o_ld_wr_addr = f(load count). The write port is combinational from the input.
  - On the acceptance that brings the count to N, the state moves to XFORM and o_xform_start pulses on the next cycle only.
  - Gaps in i_in_valid are allowed.
- XFORM: o_in_ready=0; no RAM strobes are driven. i_xform_done sampled high in any cycle of XFORM (the start-pulse cycle excluded) moves the state to UNLOAD. i_xform_done is ignored in all other states.
- UNLOAD read issue:
  - The read counter issues o_ul_rd_en with o_ul_rd_addr = rd_cnt when the occupancy plus the in-flight read is below 2. This sustains 1 sample/cycle under continuous i_out_ready.
  - Read data is captured one cycle after the strobe into the 2-entry output FIFO.
- UNLOAD output:
  - o_out_valid = FIFO not empty; data is the FIFO head. It is held stable while o_out_valid & !i_out_ready.
  - o_out_last is high on the head at sample index N-1.
  - When the N-th output handshake completes, the state returns to IDLE in the next cycle. o_in_ready stays 0 during the whole of UNLOAD.
- Simultaneous events:
  - Start pulse and i_xform_done in the same cycle: the done is ignored.
  - Final output handshake and a new i_in_valid: the input is not accepted until IDLE.
- Counters do not wrap past N. The load counter is compared against N, never modulo.

Optional Feature:
- Macro: FFT_SEQ_BITREV_EN.
- Defined: f(k) is the clog2(N)-bit bit-reversal of k, so bank 0 holds decimation-in-time input order and results unload in natural order.
- Undefined: f(k)=k, natural-order load; the transform controller is responsible for reordering.
- The unload order is natural in both cases.

Decomposition:
- Package fft_pkg:
  - state enum values IDLE/LOAD/XFORM/UNLOAD;
  - function ADDR_W(N)=clog2(N);
  - function RESULT_BANK(N)=clog2(N)%2;
  - bit-reverse function bitrev(k, ADDR_W).
- Sub-module fft_out_fifo2: 2-entry, W+W+1 wide, with push/pop, full/empty and count outputs. It is instantiated once for the output stage.

Test Plan:
- N=16, BITREV on, 16 continuous inputs k=0..15 -> o_ld_wr_addr sequence 0,8,4,12,2,...,15; o_xform_start pulses exactly once, 1 cycle after the 16th acceptance; o_phase=2.
- Inputs with random i_in_valid gaps -> exactly 16 writes; no write when i_in_valid=0; o_in_ready drops the cycle after the 16th acceptance.
- i_xform_done held high from IDLE, then real done 40 cycles after start -> UNLOAD entered only after the real done; o_ul_bank=0 for N=16.
- Unload with i_out_ready=1 constant and RAM model returning re=addr, im=~addr -> 16 back-to-back outputs 0..15; o_out_last only on 15; return to IDLE; N+2 cycles maximum.
- Unload with i_out_ready toggling 1010... and a 5-cycle stall at sample 7 -> no loss or duplication; o_out_re constant during the stall; exactly 16 handshakes.
- rst pulsed mid-LOAD (after 9 samples) and mid-UNLOAD (after 4 outputs) -> all outputs 0 the next cycle; state IDLE; a fresh 16-sample load starts at the index-0 address.

Source files
------------

// File: rtl/fft_io_sequencer_pkg.sv
// Shared types and helpers for the FFT I/O sequencer: phase encoding, address sizing, bit reversal.
// No logic or latency of its own.
// No flow control of its own.
package fft_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        XFORM  = 2'd2,
        UNLOAD = 2'd3
    } seq_state_t;

    localparam int MAX_AW = 10;

    function automatic int ADDR_W(input int n);
        return $clog2(n);
    endfunction

    // Even stage count leaves results in RAM1, odd in RAM2.
    function automatic logic RESULT_BANK(input int n);
        return (ADDR_W(n) % 2) == 1;
    endfunction

    function automatic logic [MAX_AW-1:0] bitrev(input logic [MAX_AW-1:0] k, input int aw);
        logic [MAX_AW-1:0] r;
        r = '0;
        for (int b = 0; b < MAX_AW; b++) begin
            if (b < aw) r[aw-1-b] = k[b];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_io_sequencer_out_fifo2.sv
// Two-entry output skid FIFO holding {last, re, im} for the unload stream.
// Latency: one cycle from push to head.
// Backpressure: full/count tell the producer when to stop; a push while full is accepted only with a pop.
module fft_out_fifo2 #(
    parameter int DW = 33
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [DW-1:0] push_dat,
    input  logic          pop,
    output logic [DW-1:0] pop_dat,
    output logic          full,
    output logic          empty,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    cnt;
    logic          do_push;
    logic          do_pop;

    assign full    = (cnt == 2'd2);
    assign empty   = (cnt == 2'd0);
    assign count   = cnt;
    assign pop_dat = mem[rd_ptr];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/fft_io_sequencer.sv
// FFT phase sequencer: load N samples into bank 0, kick the transform, stream results out (FFT_SEQ_BITREV_EN: bit-reversed load).
// Latency: write strobe same cycle as input accept; first output 2 cycles after UNLOAD entry, then 1/cycle.
// Backpressure: o_in_ready only in IDLE/LOAD; unload reads throttled by a 2-entry FIFO against i_out_ready.
module fft_io_sequencer
    import fft_pkg::*;
#(
    parameter int N = 16,
    parameter int I = 8,
    parameter int F = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [I+F-1:0]         i_in_re,
    input  logic [I+F-1:0]         i_in_im,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
    output logic [I+F-1:0]         o_out_re,
    output logic [I+F-1:0]         o_out_im,
    output logic                   o_out_last,
    output logic                   o_ld_wr_en,
    output logic [$clog2(N)-1:0]   o_ld_wr_addr,
    output logic [I+F-1:0]         o_ld_wr_re,
    output logic [I+F-1:0]         o_ld_wr_im,
    output logic                   o_ul_rd_en,
    output logic [$clog2(N)-1:0]   o_ul_rd_addr,
    output logic                   o_ul_bank,
    input  logic [I+F-1:0]         i_ul_rd_re,
    input  logic [I+F-1:0]         i_ul_rd_im,
    output logic                   o_xform_start,
    input  logic                   i_xform_done,
    output logic                   o_busy,
    output logic [1:0]             o_phase
);

    localparam int W  = I + F;
    localparam int AW = ADDR_W(N);
    localparam int CW = AW + 1;
    localparam int DW = 2 * W + 1;

    seq_state_t    state;
    logic          in_rdy_q;
    logic          xform_start_q;
    logic [CW-1:0] ld_cnt;
    logic [CW-1:0] rd_cnt;
    logic [CW-1:0] out_cnt;
    logic          rd_pend;
    logic          rd_last_pend;

    logic          accept;
    logic [AW-1:0] ld_addr;
    logic          rd_en;
    logic          pop;
    logic          issue_ok;
    logic [DW-1:0] head_dat;
    logic          fifo_full;
    logic          fifo_empty;
    logic [1:0]    fifo_cnt;

    assign accept = i_in_valid && in_rdy_q;

`ifdef FFT_SEQ_BITREV_EN
    assign ld_addr = AW'(bitrev(MAX_AW'(ld_cnt[AW-1:0]), AW));
`else
    assign ld_addr = ld_cnt[AW-1:0];
`endif

    // Counting the same-cycle pop lets a read issue every cycle under continuous drain.
    assign pop      = !fifo_empty && i_out_ready;
    assign issue_ok = (({1'b0, fifo_cnt} + {2'b00, rd_pend}) < (3'd2 + {2'b00, pop}))
                      && !(fifo_full && !pop);
    assign rd_en    = (state == UNLOAD) && (rd_cnt < CW'(N)) && issue_ok;

    fft_out_fifo2 #(.DW(DW)) u_out_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (rd_pend),
        .push_dat ({rd_last_pend, i_ul_rd_re, i_ul_rd_im}),
        .pop      (pop),
        .pop_dat  (head_dat),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            in_rdy_q      <= 1'b0;
            xform_start_q <= 1'b0;
            ld_cnt        <= '0;
            rd_cnt        <= '0;
            out_cnt       <= '0;
            rd_pend       <= 1'b0;
            rd_last_pend  <= 1'b0;
        end else begin
            xform_start_q <= 1'b0;
            rd_pend       <= rd_en;
            rd_last_pend  <= rd_en && (rd_cnt == CW'(N - 1));
            case (state)
                IDLE: begin
                    in_rdy_q <= 1'b1;
                    if (accept) begin
                        ld_cnt <= CW'(1);
                        state  <= LOAD;
                    end
                end
                LOAD: begin
                    in_rdy_q <= 1'b1;
                    if (accept) begin
                        ld_cnt <= ld_cnt + CW'(1);
                        if (ld_cnt == CW'(N - 1)) begin
                            state         <= XFORM;
                            xform_start_q <= 1'b1;
                            in_rdy_q      <= 1'b0;
                        end
                    end
                end
                XFORM: begin
                    in_rdy_q <= 1'b0;
                    // A done coincident with our own start pulse is stale.
                    if (i_xform_done && !xform_start_q) state <= UNLOAD;
                end
                UNLOAD: begin
                    in_rdy_q <= 1'b0;
                    if (rd_en) rd_cnt <= rd_cnt + CW'(1);
                    if (pop) begin
                        if (out_cnt == CW'(N - 1)) begin
                            state    <= IDLE;
                            in_rdy_q <= 1'b1;
                            ld_cnt   <= '0;
                            rd_cnt   <= '0;
                            out_cnt  <= '0;
                        end else begin
                            out_cnt <= out_cnt + CW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_in_ready    = in_rdy_q;
    assign o_ld_wr_en    = accept;
    assign o_ld_wr_addr  = accept ? ld_addr : '0;
    assign o_ld_wr_re    = accept ? i_in_re : '0;
    assign o_ld_wr_im    = accept ? i_in_im : '0;
    assign o_ul_rd_en    = rd_en;
    assign o_ul_rd_addr  = rd_en ? rd_cnt[AW-1:0] : '0;
    assign o_ul_bank     = RESULT_BANK(N);
    assign o_xform_start = xform_start_q;
    assign o_busy        = (state != IDLE);
    assign o_phase       = state;
    assign o_out_valid   = !fifo_empty;
    assign o_out_last    = !fifo_empty && head_dat[DW-1];
    assign o_out_re      = fifo_empty ? '0 : head_dat[2*W-1:W];
    assign o_out_im      = fifo_empty ? '0 : head_dat[W-1:0];

endmodule
